// File: rtl/c7bbiu_wr_arb_rr.sv
// Round-robin AXI write-channel arbiter: NREQ requesters share one AW/W master port.
// W bursts follow AW-acceptance order through a small W-order FIFO of requester indices.
module c7bbiu_wr_arb_rr #(
  parameter int NREQ     = 2,
  parameter int WQ_DEPTH = 4,
  parameter int ID_BASE  = 0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               axi_aw_ready,
  input  logic               axi_w_ready,
  input  logic [NREQ-1:0]    req_aw_req,
  output logic [NREQ-1:0]    biu_aw_ack,
  input  logic [NREQ*32-1:0] req_aw_addr,
  input  logic [NREQ*8-1:0]  req_aw_len,
  input  logic [NREQ*3-1:0]  req_aw_size,
  input  logic [NREQ-1:0]    req_w_req,
  output logic [NREQ-1:0]    biu_w_ack,
  input  logic [NREQ*64-1:0] req_w_data,
  input  logic [NREQ*8-1:0]  req_w_strb,
  input  logic [NREQ-1:0]    req_w_last,
  output logic               arb_wr_aw_val,
  output logic [3:0]         arb_wr_aw_id,
  output logic [31:0]        arb_wr_aw_addr,
  output logic [7:0]         arb_wr_aw_len,
  output logic [2:0]         arb_wr_aw_size,
  output logic [1:0]         arb_wr_aw_burst,
  output logic               arb_wr_aw_lock,
  output logic [3:0]         arb_wr_aw_cache,
  output logic [2:0]         arb_wr_aw_prot,
  output logic               arb_wr_w_val,
  output logic [3:0]         arb_wr_w_id,
  output logic [63:0]        arb_wr_w_data,
  output logic [7:0]         arb_wr_w_strb,
  output logic               arb_wr_w_last
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CW = $clog2(WQ_DEPTH + 1);

  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   hold_idx;
  logic [IW-1:0]   grant_idx;
  logic [IW-1:0]   scan_idx;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   wq_head;
  logic            aw_hold;
  logic            grant_vld;
  logic            aw_val;
  logic            aw_hs;
  logic            w_val;
  logic            wq_push;
  logic            wq_pop;
  logic            wq_full;
  logic            wq_empty;
  logic [NREQ-1:0] aw_eligible;
  logic [IW-1:0]   wq_mem [WQ_DEPTH];
  logic [PW-1:0]   wq_wr_ptr;
  logic [PW-1:0]   wq_rd_ptr;
  logic [CW-1:0]   wq_cnt;

  logic [31:0] aw_addr_a [NREQ];
  logic [7:0]  aw_len_a  [NREQ];
  logic [2:0]  aw_size_a [NREQ];
  logic [63:0] w_data_a  [NREQ];
  logic [7:0]  w_strb_a  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign aw_addr_a[i] = req_aw_addr[32*i +: 32];
    assign aw_len_a[i]  = req_aw_len[8*i +: 8];
    assign aw_size_a[i] = req_aw_size[3*i +: 3];
    assign w_data_a[i]  = req_w_data[64*i +: 64];
    assign w_strb_a[i]  = req_w_strb[8*i +: 8];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wq_full     = (wq_cnt == CW'(WQ_DEPTH));
  assign wq_empty    = (wq_cnt == '0);
  assign aw_eligible = req_aw_req & {NREQ{~wq_full}};

  // First eligible requester at or after rr_ptr, wrapping mod NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_vld && aw_eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Outputs are gated by resetn so they read 0 throughout an asserted reset.
  assign sel_idx = aw_hold ? hold_idx : grant_idx;
  assign aw_val  = resetn & (aw_hold | grant_vld);
  assign aw_hs   = aw_val & axi_aw_ready;
  assign wq_push = aw_hs;

  assign wq_head = wq_mem[wq_rd_ptr];
  assign w_val   = resetn & ~wq_empty & req_w_req[wq_head];
  assign wq_pop  = w_val & axi_w_ready & req_w_last[wq_head];

  always_comb begin
    biu_aw_ack      = '0;
    arb_wr_aw_val   = aw_val;
    arb_wr_aw_id    = '0;
    arb_wr_aw_addr  = '0;
    arb_wr_aw_len   = '0;
    arb_wr_aw_size  = '0;
    arb_wr_aw_burst = '0;
    arb_wr_aw_lock  = 1'b0;
    arb_wr_aw_cache = '0;
    arb_wr_aw_prot  = '0;
    if (aw_val) begin
      arb_wr_aw_id    = 4'(ID_BASE + int'(sel_idx));
      arb_wr_aw_addr  = aw_addr_a[sel_idx];
      arb_wr_aw_len   = aw_len_a[sel_idx];
      arb_wr_aw_size  = aw_size_a[sel_idx];
      arb_wr_aw_burst = 2'b01;
    end
    if (aw_hs) biu_aw_ack[sel_idx] = 1'b1;
  end

  always_comb begin
    biu_w_ack     = '0;
    arb_wr_w_val  = w_val;
    arb_wr_w_id   = '0;
    arb_wr_w_data = '0;
    arb_wr_w_strb = '0;
    arb_wr_w_last = 1'b0;
    if (w_val) begin
      arb_wr_w_id   = 4'(ID_BASE + int'(wq_head));
      arb_wr_w_data = w_data_a[wq_head];
      arb_wr_w_strb = w_strb_a[wq_head];
      arb_wr_w_last = req_w_last[wq_head];
      if (axi_w_ready) biu_w_ack[wq_head] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr    <= '0;
      aw_hold   <= 1'b0;
      hold_idx  <= '0;
      wq_wr_ptr <= '0;
      wq_rd_ptr <= '0;
      wq_cnt    <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) wq_mem[i] <= '0;
    end else begin
      if (aw_hs) begin
        rr_ptr  <= IW'((int'(sel_idx) + 1) % NREQ);
        aw_hold <= 1'b0;
      end else if (aw_val && !aw_hold) begin
        // Stalled by the slave: freeze this grant until the handshake.
        aw_hold  <= 1'b1;
        hold_idx <= grant_idx;
      end
      if (wq_push) begin
        wq_mem[wq_wr_ptr] <= sel_idx;
        wq_wr_ptr         <= ptr_inc(wq_wr_ptr);
      end
      if (wq_pop) wq_rd_ptr <= ptr_inc(wq_rd_ptr);
      case ({wq_push, wq_pop})
        2'b10:   wq_cnt <= wq_cnt + 1'b1;
        2'b01:   wq_cnt <= wq_cnt - 1'b1;
        default: wq_cnt <= wq_cnt;
      endcase
    end
  end

  a_aw_ack_onehot: assert property (@(posedge clk) disable iff (!resetn) $onehot0(biu_aw_ack));
  a_w_ack_onehot:  assert property (@(posedge clk) disable iff (!resetn) $onehot0(biu_w_ack));
  a_no_pop_empty:  assert property (@(posedge clk) disable iff (!resetn) !(wq_pop && wq_empty));
  a_no_push_full:  assert property (@(posedge clk) disable iff (!resetn)
                                    !(wq_push && wq_full && !wq_pop));

endmodule

// File: tb/tb_c7bbiu_wr_arb_rr.sv
// Directed bench for c7bbiu_wr_arb_rr with NREQ=2, WQ_DEPTH=4, ID_BASE=0.
module tb_c7bbiu_wr_arb_rr;

  logic        clk = 1'b0;
  logic        resetn;
  logic        axi_aw_ready, axi_w_ready;
  logic [1:0]  req_aw_req, req_w_req, req_w_last;
  logic [1:0]  biu_aw_ack, biu_w_ack;
  logic [63:0] req_aw_addr;
  logic [15:0] req_aw_len;
  logic [5:0]  req_aw_size;
  logic [127:0] req_w_data;
  logic [15:0] req_w_strb;
  logic        arb_wr_aw_val, arb_wr_aw_lock, arb_wr_w_val, arb_wr_w_last;
  logic [3:0]  arb_wr_aw_id, arb_wr_aw_cache, arb_wr_w_id;
  logic [31:0] arb_wr_aw_addr;
  logic [7:0]  arb_wr_aw_len, arb_wr_w_strb;
  logic [2:0]  arb_wr_aw_size, arb_wr_aw_prot;
  logic [1:0]  arb_wr_aw_burst;
  logic [63:0] arb_wr_w_data;

  logic [31:0] addr0 = 32'h1000_0040, addr1 = 32'h2000_0080;
  logic [7:0]  len0 = 8'd0, len1 = 8'd3;
  logic [2:0]  size0 = 3'd3, size1 = 3'd2;
  logic [63:0] data0 = 64'h0123_4567_89ab_cdef, data1 = 64'hfedc_ba98_7654_3210;
  logic [7:0]  strb0 = 8'hff, strb1 = 8'h0f;

  assign req_aw_addr = {addr1, addr0};
  assign req_aw_len  = {len1, len0};
  assign req_aw_size = {size1, size0};
  assign req_w_data  = {data1, data0};
  assign req_w_strb  = {strb1, strb0};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  c7bbiu_wr_arb_rr #(.NREQ(2), .WQ_DEPTH(4), .ID_BASE(0)) dut (
    .clk(clk), .resetn(resetn),
    .axi_aw_ready(axi_aw_ready), .axi_w_ready(axi_w_ready),
    .req_aw_req(req_aw_req), .biu_aw_ack(biu_aw_ack),
    .req_aw_addr(req_aw_addr), .req_aw_len(req_aw_len), .req_aw_size(req_aw_size),
    .req_w_req(req_w_req), .biu_w_ack(biu_w_ack),
    .req_w_data(req_w_data), .req_w_strb(req_w_strb), .req_w_last(req_w_last),
    .arb_wr_aw_val(arb_wr_aw_val), .arb_wr_aw_id(arb_wr_aw_id),
    .arb_wr_aw_addr(arb_wr_aw_addr), .arb_wr_aw_len(arb_wr_aw_len),
    .arb_wr_aw_size(arb_wr_aw_size), .arb_wr_aw_burst(arb_wr_aw_burst),
    .arb_wr_aw_lock(arb_wr_aw_lock), .arb_wr_aw_cache(arb_wr_aw_cache),
    .arb_wr_aw_prot(arb_wr_aw_prot),
    .arb_wr_w_val(arb_wr_w_val), .arb_wr_w_id(arb_wr_w_id),
    .arb_wr_w_data(arb_wr_w_data), .arb_wr_w_strb(arb_wr_w_strb),
    .arb_wr_w_last(arb_wr_w_last)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn = 1'b0; axi_aw_ready = 1'b1; axi_w_ready = 1'b1;
    req_aw_req = 2'b11; req_w_req = 2'b11; req_w_last = 2'b11;
    tick(); settle();
    chk("rst_aw_val", arb_wr_aw_val, 0);
    chk("rst_aw_ack", biu_aw_ack, 0);
    chk("rst_aw_addr", arb_wr_aw_addr, 0);
    chk("rst_aw_burst", arb_wr_aw_burst, 0);
    chk("rst_w_val", arb_wr_w_val, 0);
    chk("rst_w_ack", biu_w_ack, 0);

    tick(); resetn = 1'b1; req_w_req = 2'b00; settle();
    chk("rel_aw_val", arb_wr_aw_val, 1);
    chk("rel_aw_ack", biu_aw_ack, 2'b01);
    chk("rel_aw_id", arb_wr_aw_id, 0);
    chk("rel_aw_addr", arb_wr_aw_addr, addr0);
    chk("rel_aw_burst", arb_wr_aw_burst, 2'b01);
    chk("rel_aw_size", arb_wr_aw_size, size0);
    chk("rel_w_val", arb_wr_w_val, 0);

    // Round-robin with both requesting; FIFO fills with 0,1,0,1.
    tick(); settle();
    chk("rr1_ack", biu_aw_ack, 2'b10);
    chk("rr1_id", arb_wr_aw_id, 1);
    chk("rr1_addr", arb_wr_aw_addr, addr1);
    chk("rr1_len", arb_wr_aw_len, len1);
    tick(); settle();
    chk("rr2_ack", biu_aw_ack, 2'b01);
    chk("rr2_id", arb_wr_aw_id, 0);
    tick(); settle();
    chk("rr3_ack", biu_aw_ack, 2'b10);
    chk("rr3_id", arb_wr_aw_id, 1);

    // FIFO full: no AW; requester 1 is not at the W head.
    tick(); req_w_req = 2'b10; settle();
    chk("full_aw_val", arb_wr_aw_val, 0);
    chk("full_aw_ack", biu_aw_ack, 0);
    chk("full_aw_addr", arb_wr_aw_addr, 0);
    chk("nohead_w_val", arb_wr_w_val, 0);
    chk("nohead_w_ack", biu_w_ack, 0);

    tick(); req_w_req = 2'b01; req_w_last = 2'b01; settle();
    chk("pop_w_val", arb_wr_w_val, 1);
    chk("pop_w_ack", biu_w_ack, 2'b01);
    chk("pop_w_id", arb_wr_w_id, 0);
    chk("pop_w_data", arb_wr_w_data, data0);
    chk("pop_w_strb", arb_wr_w_strb, strb0);
    chk("pop_w_last", arb_wr_w_last, 1);
    chk("pop_aw_val", arb_wr_aw_val, 0);

    tick(); req_w_req = 2'b00; settle();
    chk("refill_aw_val", arb_wr_aw_val, 1);
    chk("refill_aw_ack", biu_aw_ack, 2'b01);
    chk("refill_aw_id", arb_wr_aw_id, 0);

    // Drain in acceptance order 1,0,1,0.
    tick(); req_aw_req = 2'b00; req_w_req = 2'b11; req_w_last = 2'b11; settle();
    chk("drain0_w_id", arb_wr_w_id, 1);
    chk("drain0_w_ack", biu_w_ack, 2'b10);
    chk("drain0_w_data", arb_wr_w_data, data1);
    tick(); settle();
    chk("drain1_w_id", arb_wr_w_id, 0);
    chk("drain1_w_ack", biu_w_ack, 2'b01);
    tick(); settle();
    chk("drain2_w_id", arb_wr_w_id, 1);
    tick(); settle();
    chk("drain3_w_id", arb_wr_w_id, 0);
    tick(); settle();
    chk("drained_w_val", arb_wr_w_val, 0);
    chk("drained_w_ack", biu_w_ack, 0);

    // Stall hold: rr_ptr is 1, req0 held 3 cycles while req1 rises.
    tick(); req_w_req = 2'b00; req_aw_req = 2'b01; axi_aw_ready = 1'b0; settle();
    chk("st0_val", arb_wr_aw_val, 1);
    chk("st0_id", arb_wr_aw_id, 0);
    chk("st0_ack", biu_aw_ack, 0);
    tick(); req_aw_req = 2'b11; settle();
    chk("st1_id", arb_wr_aw_id, 0);
    chk("st1_addr", arb_wr_aw_addr, addr0);
    tick(); settle();
    chk("st2_val", arb_wr_aw_val, 1);
    chk("st2_id", arb_wr_aw_id, 0);
    tick(); axi_aw_ready = 1'b1; settle();
    chk("st3_ack", biu_aw_ack, 2'b01);
    chk("st3_id", arb_wr_aw_id, 0);
    tick(); req_aw_req = 2'b10; settle();
    chk("st4_ack", biu_aw_ack, 2'b10);
    chk("st4_id", arb_wr_aw_id, 1);
    chk("st4_addr", arb_wr_aw_addr, addr1);

    tick(); req_aw_req = 2'b00; req_w_req = 2'b11; req_w_last = 2'b11; settle();
    chk("sd0_w_id", arb_wr_w_id, 0);
    tick(); settle();
    chk("sd1_w_id", arb_wr_w_id, 1);

    // W ordering: req1 len=3 then req0 len=0.
    tick(); req_w_req = 2'b00; req_aw_req = 2'b10; settle();
    chk("wo_aw1_ack", biu_aw_ack, 2'b10);
    chk("wo_aw1_len", arb_wr_aw_len, 3);
    tick(); req_aw_req = 2'b01; settle();
    chk("wo_aw0_ack", biu_aw_ack, 2'b01);
    chk("wo_aw0_len", arb_wr_aw_len, 0);
    tick(); req_aw_req = 2'b00; req_w_req = 2'b11; req_w_last = 2'b01; settle();
    chk("wo_b1_ack", biu_w_ack, 2'b10);
    chk("wo_b1_id", arb_wr_w_id, 1);
    chk("wo_b1_last", arb_wr_w_last, 0);
    chk("wo_b1_strb", arb_wr_w_strb, strb1);
    tick(); settle();
    chk("wo_b2_ack", biu_w_ack, 2'b10);
    tick(); settle();
    chk("wo_b3_ack", biu_w_ack, 2'b10);
    tick(); req_w_last = 2'b11; settle();
    chk("wo_b4_ack", biu_w_ack, 2'b10);
    chk("wo_b4_last", arb_wr_w_last, 1);
    tick(); settle();
    chk("wo_b5_ack", biu_w_ack, 2'b01);
    chk("wo_b5_id", arb_wr_w_id, 0);
    chk("wo_b5_data", arb_wr_w_data, data0);
    tick(); req_w_req = 2'b00; settle();
    chk("wo_empty_w_val", arb_wr_w_val, 0);

    // Reset mid-burst: rr_ptr is 1 before reset.
    tick(); len0 = 8'd3; req_aw_req = 2'b01; settle();
    chk("mb_aw_ack", biu_aw_ack, 2'b01);
    tick(); req_aw_req = 2'b00; req_w_req = 2'b01; req_w_last = 2'b00; settle();
    chk("mb_b1_ack", biu_w_ack, 2'b01);
    tick(); settle();
    chk("mb_b2_ack", biu_w_ack, 2'b01);
    tick(); resetn = 1'b0; req_aw_req = 2'b11; settle();
    chk("mr_w_val", arb_wr_w_val, 0);
    chk("mr_w_data", arb_wr_w_data, 0);
    chk("mr_aw_val", arb_wr_aw_val, 0);
    tick(); resetn = 1'b1; settle();
    chk("mr_rel_aw_ack", biu_aw_ack, 2'b01);
    chk("mr_rel_aw_id", arb_wr_aw_id, 0);
    chk("mr_rel_w_val", arb_wr_w_val, 0);
    tick(); req_aw_req = 2'b00; req_w_req = 2'b00;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
